// File: rtl/avalon_timer_pkg.sv
// Shared constants for the avalon_timer peripheral: register offsets and bit positions.
package avalon_timer_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PRESC  = 3'd1;
  localparam logic [2:0] REG_CMP    = 3'd2;
  localparam logic [2:0] REG_CNT    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IE     = 2;
  localparam int STAT_MATCH  = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider: tick pulses every presc+1 enabled clocks; pcnt only ever matches on equality,
// so lowering presc below pcnt forces a full wrap before the next tick.
module timer_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] presc,
  output logic         tick
);

  logic [W-1:0] pcnt;

  assign tick = en & (pcnt == presc);

  always_ff @(posedge clk) begin
    if (rst || clr || !en || tick) pcnt <= '0;
    else                           pcnt <= pcnt + 1'b1;
  end

endmodule

// File: rtl/avalon_timer.sv
// Memory-mapped 8-bit timer/compare slave: CTRL/PRESC/CMP/CNT/STATUS registers,
// sticky compare match and a level interrupt (MATCH & IE).
module avalon_timer
  import avalon_timer_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] AvalonAddr_i,
  input  logic              AvalonRead_i,
  input  logic              AvalonWrite_i,
  input  logic [DATA_W-1:0] AvalonWriteData_i,
  output logic [DATA_W-1:0] AvalonReadData_o,
  output logic              TimerIrq_o
);

  logic              en, reload, ie, match;
  logic [DATA_W-1:0] presc, cmp, cnt;
  logic [2:0]        off;
  logic              wr_ctrl, wr_presc, wr_cmp, wr_cnt, wr_stat;
  logic              tick_raw, tick, pclr;
  logic [DATA_W-1:0] rd_mux;
  logic              addr_unused;

  assign off         = AvalonAddr_i[2:0];
  assign addr_unused = ^AvalonAddr_i[ADDR_W-1:3];

  assign wr_ctrl  = AvalonWrite_i && (off == REG_CTRL);
  assign wr_presc = AvalonWrite_i && (off == REG_PRESC);
  assign wr_cmp   = AvalonWrite_i && (off == REG_CMP);
  assign wr_cnt   = AvalonWrite_i && (off == REG_CNT);
  assign wr_stat  = AvalonWrite_i && (off == REG_STATUS);

  // A CNT load restarts the prescale interval and swallows a coincident tick.
  assign pclr = wr_cnt | (wr_ctrl & ~AvalonWriteData_i[CTRL_EN]);
  assign tick = tick_raw & ~wr_cnt;

  timer_prescaler #(.W(DATA_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (pclr),
    .presc (presc),
    .tick  (tick_raw)
  );

  always_comb begin
    rd_mux = '0;
    case (off)
      REG_CTRL: begin
        rd_mux[CTRL_EN]     = en;
        rd_mux[CTRL_RELOAD] = reload;
        rd_mux[CTRL_IE]     = ie;
      end
      REG_PRESC:  rd_mux = presc;
      REG_CMP:    rd_mux = cmp;
      REG_CNT:    rd_mux = cnt;
      REG_STATUS: rd_mux[STAT_MATCH] = match;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en               <= 1'b0;
      reload           <= 1'b0;
      ie               <= 1'b0;
      match            <= 1'b0;
      presc            <= '0;
      cmp              <= '0;
      cnt              <= '0;
      AvalonReadData_o <= '0;
    end else begin
      // Later assignments win: clear < tick effects < register writes.
      if (wr_stat && AvalonWriteData_i[STAT_MATCH]) match <= 1'b0;
      if (tick) begin
        if (cnt == cmp) begin
          match <= 1'b1;
          if (reload) cnt <= '0;
          else        en  <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (wr_ctrl) begin
        en     <= AvalonWriteData_i[CTRL_EN];
        reload <= AvalonWriteData_i[CTRL_RELOAD];
        ie     <= AvalonWriteData_i[CTRL_IE];
      end
      if (wr_presc) presc <= AvalonWriteData_i;
      if (wr_cmp)   cmp   <= AvalonWriteData_i;
      if (wr_cnt)   cnt   <= AvalonWriteData_i;
      if (AvalonRead_i) AvalonReadData_o <= rd_mux;
    end
  end

  assign TimerIrq_o = match & ie;

endmodule

// File: tb/tb_avalon_timer.sv
// Self-checking bench for avalon_timer: vector table, hand-built corner sequences,
// then randomized bus traffic against a register-array reference model.
module tb_avalon_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] addr = '0;
  logic       rd = 1'b0, wr = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       irq;

  int ntot = 0, npass = 0;

  avalon_timer #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .AvalonAddr_i      (addr),
    .AvalonRead_i      (rd),
    .AvalonWrite_i     (wr),
    .AvalonWriteData_i (wdata),
    .AvalonReadData_o  (rdata),
    .TimerIrq_o        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: the register file as the bus sees it, indexed by offset.
  logic [7:0] mr [8];
  int         mp;
  logic [7:0] m_rdata;

  function automatic logic m_irq();
    return mr[4][0] & mr[0][2];
  endfunction

  task automatic model_step(bit r, bit rdq, bit wrq, logic [2:0] a, logic [7:0] d);
    logic [7:0] nr [8];
    int  np;
    bit  en, tk, setm;
    if (r) begin
      foreach (mr[i]) mr[i] = 8'h00;
      mp = 0;
      m_rdata = 8'h00;
    end else begin
      if (rdq) m_rdata = mr[a];
      en   = mr[0][0];
      tk   = en && (mp == int'(mr[1])) && !(wrq && a == 3'd3);
      np   = !en ? 0 : ((mp == int'(mr[1])) ? 0 : (mp + 1) % 256);
      nr   = mr;
      setm = 1'b0;
      if (tk) begin
        if (mr[3] == mr[2]) begin
          setm = 1'b1;
          if (mr[0][1]) nr[3] = 8'h00;
          else          nr[0][0] = 1'b0;
        end else begin
          nr[3] = mr[3] + 8'd1;
        end
      end
      if (wrq) begin
        case (a)
          3'd0: begin nr[0] = {5'b0, d[2:0]}; if (!d[0]) np = 0; end
          3'd1: nr[1] = d;
          3'd2: nr[2] = d;
          3'd3: begin nr[3] = d; np = 0; end
          3'd4: if (d[0]) nr[4] = 8'h00;
          default: ;
        endcase
      end
      if (setm) nr[4] = 8'h01;
      mr = nr;
      mp = np;
    end
  endtask

  task automatic step(bit r, bit rdq, bit wrq, logic [5:0] a, logic [7:0] d);
    rst = r; rd = rdq; wr = wrq; addr = a; wdata = d;
    @(posedge clk);
    model_step(r, rdq, wrq, a[2:0], d);
    #1;
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle(); step(0, 0, 0, 6'd0, 8'h00); endtask
  task automatic wreg(logic [2:0] a, logic [7:0] d); step(0, 0, 1, {3'b000, a}, d); endtask
  task automatic rreg(logic [2:0] a); step(0, 1, 0, {3'b000, a}, 8'h00); endtask

  typedef struct {
    bit         rd;
    bit         wr;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] er;
    bit         er_chk;
    bit         ei;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit r_, bit w_, logic [2:0] a_, logic [7:0] d_,
                             logic [7:0] er_, bit c_, bit ei_);
    vec_t t;
    t.rd = r_; t.wr = w_; t.a = a_; t.d = d_; t.er = er_; t.er_chk = c_; t.ei = ei_;
    return t;
  endfunction

  initial begin
    logic [7:0] cnt_seq [9];
    int r;
    logic [5:0] ra;
    logic [7:0] rdv;

    // Reset values, then auto-reload (PRESC=1, CMP=3 -> 8-clock period).
    for (int i = 0; i < 8; i++) tbl.push_back(v(1, 0, 3'(i), 8'h00, 8'h00, 1, 0));
    tbl.push_back(v(0, 1, 3'd1, 8'h01, 8'h00, 1, 0));
    tbl.push_back(v(0, 1, 3'd2, 8'h03, 8'h00, 1, 0));
    tbl.push_back(v(0, 1, 3'd0, 8'h07, 8'h00, 1, 0));
    cnt_seq = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd0};
    for (int i = 0; i < 9; i++) tbl.push_back(v(1, 0, 3'd3, 8'h00, cnt_seq[i], 1, i >= 7));
    tbl.push_back(v(1, 0, 3'd4, 8'h00, 8'h01, 1, 1));
    tbl.push_back(v(0, 1, 3'd4, 8'h01, 8'h01, 1, 0));
    tbl.push_back(v(1, 0, 3'd4, 8'h00, 8'h00, 1, 0));
    tbl.push_back(v(0, 1, 3'd0, 8'h00, 8'h00, 1, 0));

    step(1, 0, 0, 6'd0, 8'h00);
    step(1, 0, 0, 6'd0, 8'h00);
    chk("reset rdata", rdata, 8'h00);
    chk("reset irq", {7'b0, irq}, 8'h00);

    foreach (tbl[i]) begin
      step(0, tbl[i].rd, tbl[i].wr, {3'b000, tbl[i].a}, tbl[i].d);
      if (tbl[i].er_chk) chk($sformatf("vec%0d rdata", i), rdata, tbl[i].er);
      chk($sformatf("vec%0d irq", i), {7'b0, irq}, {7'b0, tbl[i].ei});
    end

    // One-shot: PRESC=0, CMP=2, EN only; EN auto-clears on match, CNT holds.
    wreg(3'd3, 8'h00); wreg(3'd4, 8'h01); wreg(3'd1, 8'h00); wreg(3'd2, 8'h02);
    wreg(3'd0, 8'h01);
    idle();
    rreg(3'd4); chk("oneshot pre-match status", rdata, 8'h00);
    idle();
    rreg(3'd0); chk("oneshot ctrl", rdata, 8'h00);
    rreg(3'd3); chk("oneshot cnt", rdata, 8'h02);
    rreg(3'd4); chk("oneshot status", rdata, 8'h01);
    chk("oneshot irq (IE=0)", {7'b0, irq}, 8'h00);
    wreg(3'd4, 8'h01);

    // Clear/set collision, then a clear with no match (combined with a read).
    wreg(3'd3, 8'h00); wreg(3'd2, 8'h02); wreg(3'd0, 8'h07);
    idle(); idle();
    wreg(3'd4, 8'h01);
    chk("collision irq", {7'b0, irq}, 8'h01);
    step(0, 1, 1, 6'd4, 8'h01);
    chk("rw same cycle rdata", rdata, 8'h01);
    chk("clear irq falls", {7'b0, irq}, 8'h00);
    rreg(3'd4); chk("status after clear", rdata, 8'h00);
    wreg(3'd0, 8'h00); wreg(3'd4, 8'h01);

    // CNT write landing on a tick, then wrap 0xFF -> 0x00.
    wreg(3'd2, 8'h80); wreg(3'd3, 8'h00); wreg(3'd0, 8'h01);
    idle();
    wreg(3'd3, 8'hFE);
    rreg(3'd3); chk("cnt write vs tick", rdata, 8'hFE);
    rreg(3'd3); chk("cnt ff", rdata, 8'hFF);
    rreg(3'd3); chk("cnt wrap", rdata, 8'h00);
    wreg(3'd0, 8'h00);

    // Reset in the middle of a running, interrupting timer with a concurrent access.
    wreg(3'd2, 8'h01); wreg(3'd3, 8'h00); wreg(3'd0, 8'h07);
    idle(); idle(); idle();
    chk("irq before midreset", {7'b0, irq}, 8'h01);
    step(1, 1, 1, 6'd0, 8'h07);
    chk("midreset irq", {7'b0, irq}, 8'h00);
    chk("midreset rdata", rdata, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rreg(3'(i)); chk($sformatf("midreset reg%0d", i), rdata, 8'h00);
    end
    idle(); idle();
    rreg(3'd3); chk("midreset stopped", rdata, 8'h00);

    // Random traffic with aliased upper address bits, checked against the model.
    wreg(3'd1, 8'h02); wreg(3'd2, 8'h04); wreg(3'd0, 8'h07);
    for (int i = 0; i < 1500; i++) begin
      r   = int'($urandom_range(0, 15));
      ra  = 6'($urandom);
      rdv = 8'($urandom);
      case (ra[2:0])
        3'd0: rdv[0] = ($urandom_range(0, 3) != 0);
        3'd1: rdv = 8'($urandom_range(0, 3));
        3'd2: rdv = 8'($urandom_range(0, 6));
        3'd3: rdv = 8'($urandom_range(0, 8));
        default: ;
      endcase
      if (r < 9)       step(0, 0, 0, ra, rdv);
      else if (r < 12) step(0, 1, 0, ra, rdv);
      else if (r < 15) step(0, 0, 1, ra, rdv);
      else             step(0, 1, 1, ra, rdv);
      chk("rand rdata", rdata, m_rdata);
      chk("rand irq", {7'b0, irq}, {7'b0, m_irq()});
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
